// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_pkg : shared constants for the fetch stage          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package instruction_fetch_pkg;

  localparam int         c_opcode_msb = 27;
  localparam int         c_opcode_lsb = 24;
  localparam logic [3:0] c_op_nop     = 4'h0;

  localparam logic [27:0] c_bubble_word = {c_op_nop, 24'd0};

  localparam logic [1:0] c_st_boot     = 2'd0;
  localparam logic [1:0] c_st_run      = 2'd1;
  localparam logic [1:0] c_st_redirect = 2'd2;

  localparam logic [1:0] c_pc_hold = 2'd0;
  localparam logic [1:0] c_pc_incr = 2'd1;
  localparam logic [1:0] c_pc_load = 2'd2;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_pc_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_register : program counter with hold / increment / load select    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pc_register
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_sel,
  input  logic [ADDR_WIDTH-1:0] i_target,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // Increment wraps naturally modulo 2^ADDR_WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      case (i_sel)
        c_pc_incr: r_pc <= r_pc + ADDR_WIDTH'(1);
        c_pc_load: r_pc <= i_target;
        default:   r_pc <= r_pc;
      endcase
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch : PC, ROM addressing, IF/ID register, redirects    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    INSTR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FLUSH_CYCLES = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0]  oPC,
  output logic                   oValid
);

  localparam logic [INSTR_WIDTH-1:0] c_bubble = INSTR_WIDTH'(c_op_nop) << c_opcode_lsb;
  localparam logic [1:0]             c_flush  = 2'(FLUSH_CYCLES);

  logic [1:0]             r_state;
  logic [1:0]             r_flush_cnt;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_pc_out;
  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  w_pc;
  logic [1:0]             w_pc_sel;
  logic                   w_redirect;

  // Branches are ignored while BOOT so the first cycle out of reset is always a bubble
  assign w_redirect = iBranchTaken && (r_state != c_st_boot);

  always_comb begin
    w_pc_sel = c_pc_hold;
    if (w_redirect) begin
      w_pc_sel = c_pc_load;
    end else if ((r_state == c_st_run) && !iStall) begin
      w_pc_sel = c_pc_incr;
    end
  end

  pc_register #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_register (
    .clk      (Clock),
    .rst      (Reset),
    .i_sel    (w_pc_sel),
    .i_target (iBranchTarget),
    .o_pc     (w_pc)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= c_st_boot;
      r_flush_cnt <= 2'd0;
      r_instr     <= c_bubble;
      r_pc_out    <= '0;
      r_valid     <= 1'b0;
    end else if (w_redirect) begin
      r_instr  <= c_bubble;
      r_pc_out <= iBranchTarget;
      r_valid  <= 1'b0;
      if (FLUSH_CYCLES == 0) begin
        r_state <= c_st_run;
      end else begin
        r_state     <= c_st_redirect;
        r_flush_cnt <= c_flush;
      end
    end else begin
      case (r_state)
        c_st_boot: r_state <= c_st_run;
        c_st_run: begin
          if (!iStall) begin
            r_instr  <= iInstruction;
            r_pc_out <= w_pc;
            r_valid  <= 1'b1;
          end
        end
        c_st_redirect: begin
          // Stall freezes the flush count; last bubble hands over to RUN
          if (!iStall) begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
            if (r_flush_cnt <= 2'd1) begin
              r_state <= c_st_run;
            end
          end
        end
        default: r_state <= c_st_boot;
      endcase
    end
  end

  assign oAddress     = w_pc;
  assign oInstruction = r_instr;
  assign oPC          = r_pc_out;
  assign oValid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch : scoreboard bench for instruction_fetch         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br;
  logic [15:0] tgt;
  logic [15:0] addr;
  logic [27:0] rom_data;
  logic [27:0] instr;
  logic [15:0] pc;
  logic        valid;

  typedef struct {
    string       tag;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instruction_fetch #(
    .ADDR_WIDTH   (16),
    .INSTR_WIDTH  (28),
    .RESET_VECTOR (16'h0000),
    .FLUSH_CYCLES (1)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .iStall        (stall),
    .iBranchTaken  (br),
    .iBranchTarget (tgt),
    .oAddress      (addr),
    .iInstruction  (rom_data),
    .oInstruction  (instr),
    .oPC           (pc),
    .oValid        (valid)
  );

  // Combinational ROM: data = address + 100
  assign rom_data = {12'd0, addr} + 28'd100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [27:0] exp_instr(input logic v, input logic [15:0] p);
    return v ? ({12'd0, p} + 28'd100) : c_bubble_word;
  endfunction

  task automatic check_outputs(input exp_t e);
    check({e.tag, "_valid"}, 64'(valid), 64'(e.valid));
    check({e.tag, "_pc"},    64'(pc),    64'(e.pc));
    check({e.tag, "_instr"}, 64'(instr), 64'(exp_instr(e.valid, e.pc)));
    check({e.tag, "_addr"},  64'(addr),  64'(e.addr));
  endtask

  task automatic step(input string tag, input logic s, input logic b, input logic [15:0] t,
                      input logic ev, input logic [15:0] epc, input logic [15:0] eaddr);
    exp_t e;
    stall = s;
    br    = b;
    tgt   = t;
    sb.push_back('{tag, ev, epc, eaddr});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(e);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs('{"reset", 1'b0, 16'h0, 16'h0});
    rst = 1'b0;

    step("boot",  0, 0, 0, 0, 16'd0, 16'd0);
    step("seq0",  0, 0, 0, 1, 16'd0, 16'd1);
    step("seq1",  0, 0, 0, 1, 16'd1, 16'd2);
    step("seq2",  0, 0, 0, 1, 16'd2, 16'd3);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 1, 16'd2, 16'd3);
    step("post_stall", 0, 0, 0, 1, 16'd3, 16'd4);
    step("seq4",  0, 0, 0, 1, 16'd4, 16'd5);

    // Redirect to 8 from PC=5: two bubbles then the target
    step("br8",    0, 1, 16'd8, 0, 16'd8, 16'd8);
    step("flush8", 0, 0, 0,     0, 16'd8, 16'd8);
    step("tgt8",   0, 0, 0,     1, 16'd8, 16'd9);
    step("tgt9",   0, 0, 0,     1, 16'd9, 16'd10);

    // Branch wins over stall, then a second branch reloads the flush counter
    step("br_stall",    1, 1, 16'd2,  0, 16'd2,  16'd2);
    step("br14",        0, 1, 16'd14, 0, 16'd14, 16'd14);
    step("redir_stall", 1, 0, 0,      0, 16'd14, 16'd14);
    step("flush14",     0, 0, 0,      0, 16'd14, 16'd14);
    step("tgt14",       0, 0, 0,      1, 16'd14, 16'd15);
    step("tgt15",       0, 0, 0,      1, 16'd15, 16'd16);

    step("br_wrap",  0, 1, 16'hFFFE, 0, 16'hFFFE, 16'hFFFE);
    step("flush_w",  0, 0, 0,        0, 16'hFFFE, 16'hFFFE);
    step("wrap_fe",  0, 0, 0,        1, 16'hFFFE, 16'hFFFF);
    step("wrap_ff",  0, 0, 0,        1, 16'hFFFF, 16'h0000);
    step("wrap_00",  0, 0, 0,        1, 16'h0000, 16'h0001);

    // Asynchronous reset in the middle of a redirect
    step("br20", 0, 1, 16'h20, 0, 16'h20, 16'h20);
    br  = 1'b0;
    rst = 1'b1;
    #2;
    check_outputs('{"async_rst", 1'b0, 16'h0, 16'h0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("boot2_br_ignored", 0, 1, 16'h30, 0, 16'd0, 16'd0);
    step("refetch0", 0, 0, 0, 1, 16'd0, 16'd1);
    step("refetch1", 0, 0, 0, 1, 16'd1, 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the 28-bit-instruction processor; sits directly upstream of the instruction ROM and the decode stage.
- Owns the program counter and drives the ROM address; the ROM is combinational.
- Registers the returned word into the IF/ID pipeline register.
- Handles stalls and branch/jump redirects, inserting NOP bubbles after a redirect.

Parameters:
- ADDR_WIDTH, 16, PC and ROM address width.
- INSTR_WIDTH, 28, instruction width: opcode [27:24], operands [23:0].
- RESET_VECTOR, 0, PC value after reset.
- FLUSH_CYCLES, 1, extra bubbles after a redirect; legal range 0..3.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- iStall  input  1  decode/execute hazard; hold PC and IF/ID register.
- iBranchTaken  input  1  branch/jump resolved taken this cycle.
- iBranchTarget  input  ADDR_WIDTH  redirect address; valid when iBranchTaken=1.
- oAddress  output  ADDR_WIDTH  ROM address; equals the PC register, no combinational path from inputs.
- iInstruction  input  INSTR_WIDTH  ROM data for oAddress, same cycle.
- oInstruction  output  INSTR_WIDTH  IF/ID instruction register.
- oPC  output  ADDR_WIDTH  address of the word in oInstruction.
- oValid  output  1  1 = oInstruction is a real fetched word; 0 = bubble.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - PC=RESET_VECTOR, oInstruction={`NOP,24'd0}, oPC=0, oValid=0.
  - State=BOOT, flush counter=0.
- States:
  - BOOT: exactly one cycle after reset release; PC held, bubble output; then RUN.
  - RUN, not stalled, no branch, per edge:
    - oInstruction<=iInstruction, oPC<=PC, oValid<=1.
    - PC<=PC+1, modulo 2^ADDR_WIDTH (16'hFFFF wraps to 0).
  - RUN, iStall=1 and no branch: PC, oInstruction, oPC, oValid all hold. The stall has no cycle limit.
  - Branch (iBranchTaken=1), in any state except BOOT:
    - Highest priority; overrides iStall in the same cycle.
    - PC<=iBranchTarget, oInstruction<={`NOP,24'd0}, oValid<=0, oPC<=iBranchTarget.
    - If FLUSH_CYCLES=0: next state RUN. Otherwise: state REDIRECT, counter<=FLUSH_CYCLES.
  - REDIRECT, per edge:
    - PC held at target, bubble output, counter decrements.
    - iStall freezes the counter.
    - Counter reaching 0 moves to RUN.
    - A new branch in REDIRECT restarts with the new target and reloads the counter.
  - iBranchTaken during BOOT is ignored.
- Latency:
  - Address to oInstruction: 1 cycle.
  - Taken branch to first valid target word: 1+FLUSH_CYCLES cycles after the branch edge.
- Sequencing: oValid=1 only for sequentially fetched words. oPC increments by 1 per valid word, except across a redirect.
- The stage does not decode opcodes; JMP/BLE resolution is downstream and arrives through iBranchTaken.

Decomposition:
- Opcode constants (`NOP etc.) and the register names come from the shared definitions include.
- Add to it: the bubble word, the field positions (OPCODE_MSB=27, OPCODE_LSB=24), and the state encodings for BOOT/RUN/REDIRECT.
- One natural sub-module, pc_register: holds the PC and selects hold / +1 / target / reset vector.
- FSM and IF/ID register stay in the top.

Test Plan:
- Sequential fetch: release reset, ROM returns address+100 as data -> oValid=0 for the BOOT cycle, then oPC=0,1,2,3 with oInstruction=100,101,102,103 on consecutive cycles.
- Stall: assert iStall for 3 cycles while oPC=2 -> oPC=2, oInstruction and oAddress=3 hold for 3 cycles, then oPC=3 follows.
- Branch, FLUSH_CYCLES=1: iBranchTaken with target 8 at PC=5 -> 2 bubble cycles (oValid=0, oInstruction={`NOP,0}), then oPC=8, 9, ...
- Branch during stall, plus back-to-back branches: iStall=1 and iBranchTaken=1 with target 2 -> redirect taken. A second branch to target 14 during REDIRECT -> counter reloads, first valid oPC=14.
- Wrap and reset: branch to 16'hFFFE -> oPC=FFFE, FFFF, 0000. Assert Reset asynchronously mid-REDIRECT -> outputs immediately equal reset values, BOOT cycle, fetch restarts at 0.
